// File: rtl/f2i_pipe.sv
// f2i_pipe: two-stage elastic pipeline converting an IEEE-754 single-precision
// float into a 32-bit two's-complement integer, truncating toward zero.
// Stage 1 classifies the input and registers sign, mantissa and shift amount.
// Stage 2 performs the shift/negate and holds the result until it is accepted.
module f2i_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        p_lost,
  output logic        invalid
);

  // Result classes decided in stage 1 so stage 2 only has to shift and negate.
  typedef enum logic [1:0] {
    CLS_SMALL,  // |a| < 1, zero or subnormal: result 0, p_lost precomputed
    CLS_NUM,    // 127 <= e <= 157: regular conversion through the shifter
    CLS_MIN,    // exactly -2^31: representable, no flags
    CLS_INV     // NaN, infinity or out of range: saturate and flag
  } cls_t;

  // Stage 1 registers
  logic        s1_valid_q, s1_valid_d;
  cls_t        s1_cls_q, s1_cls_d;
  logic        s1_sign_q, s1_sign_d;
  logic [23:0] s1_mant_q, s1_mant_d;
  logic [4:0]  s1_shamt_q, s1_shamt_d;
  logic        s1_plost_q, s1_plost_d;

  // Stage 2 (output) registers
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] d_q, d_d;
  logic        p_lost_q, p_lost_d;
  logic        invalid_q, invalid_d;

  // Handshake and datapath intermediates
  logic        s2_load;
  logic        s1_advance;
  logic        in_fire;
  logic [7:0]  exp_f;
  logic [22:0] frac_f;
  cls_t        dec_cls;
  logic        dec_plost;
  logic [4:0]  dec_shamt;
  logic [54:0] wide;
  logic [31:0] mag;
  logic        frac_lost;
  logic [31:0] res_d;
  logic        res_plost;
  logic        res_inv;

  // Elastic handshake; outputs are forced quiet while reset is held.
  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    s1_advance = s1_valid_q && s2_load;
    in_ready   = !rst && (!s1_valid_q || s2_load);
    in_fire    = in_valid && in_ready;
    out_valid  = s2_valid_q && !rst;
    d          = rst ? 32'd0 : d_q;
    p_lost     = !rst && p_lost_q;
    invalid    = !rst && invalid_q;
  end

  // Stage 1 decode; the shift amount e-127 equals (e[4:0]+1) mod 32 for 127..157.
  always_comb begin
    exp_f     = a[30:23];
    frac_f    = a[22:0];
    dec_cls   = CLS_SMALL;
    dec_plost = 1'b0;
    dec_shamt = 5'd0;
    if (exp_f == 8'd255) begin
      dec_cls = CLS_INV;
    end else if (exp_f == 8'd0) begin
      dec_plost = |frac_f;
    end else if (exp_f < 8'd127) begin
      dec_plost = 1'b1;
    end else if (exp_f <= 8'd157) begin
      dec_cls   = CLS_NUM;
      dec_shamt = exp_f[4:0] + 5'd1;
    end else if (exp_f == 8'd158 && a[31] && frac_f == 23'd0) begin
      dec_cls = CLS_MIN;
    end else begin
      dec_cls = CLS_INV;
    end
  end

  // Stage 2 datapath: 55-bit fixed point with 23 fraction bits keeps every mantissa bit.
  always_comb begin
    wide      = {31'd0, s1_mant_q} << s1_shamt_q;
    mag       = wide[54:23];
    frac_lost = |wide[22:0];
    res_d     = 32'd0;
    res_plost = 1'b0;
    res_inv   = 1'b0;
    case (s1_cls_q)
      CLS_SMALL: res_plost = s1_plost_q;
      CLS_NUM: begin
        res_d     = s1_sign_q ? (~mag + 32'd1) : mag;
        res_plost = frac_lost;
      end
      CLS_MIN: res_d = 32'h8000_0000;
      default: begin
        res_d   = 32'h8000_0000;
        res_inv = 1'b1;
      end
    endcase
  end

  // Next-state for both stages: a stage loads when empty or draining this cycle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cls_d   = s1_cls_q;
    s1_sign_d  = s1_sign_q;
    s1_mant_d  = s1_mant_q;
    s1_shamt_d = s1_shamt_q;
    s1_plost_d = s1_plost_q;
    s2_valid_d = s2_valid_q;
    d_d        = d_q;
    p_lost_d   = p_lost_q;
    invalid_d  = invalid_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_cls_d   = dec_cls;
      s1_sign_d  = a[31];
      s1_mant_d  = {1'b1, frac_f};
      s1_shamt_d = dec_shamt;
      s1_plost_d = dec_plost;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_advance) begin
      d_d      = res_d;
      p_lost_d = res_plost;
      invalid_d = res_inv;
    end
  end

  // State registers with synchronous reset that flushes all in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= CLS_SMALL;
      s1_sign_q  <= 1'b0;
      s1_mant_q  <= 24'd0;
      s1_shamt_q <= 5'd0;
      s1_plost_q <= 1'b0;
      s2_valid_q <= 1'b0;
      d_q        <= 32'd0;
      p_lost_q   <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cls_q   <= s1_cls_d;
      s1_sign_q  <= s1_sign_d;
      s1_mant_q  <= s1_mant_d;
      s1_shamt_q <= s1_shamt_d;
      s1_plost_q <= s1_plost_d;
      s2_valid_q <= s2_valid_d;
      d_q        <= d_d;
      p_lost_q   <= p_lost_d;
      invalid_q  <= invalid_d;
    end
  end

endmodule

// File: tb/tb_f2i_pipe.sv
// Testbench for f2i_pipe: directed vectors, stall/reset scenarios and random
// traffic, all checked against a value-level float-to-int reference model.
module tb_f2i_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] d;
   logic        p_lost;
   logic        invalid;

   int checkCount;
   int passCount;

   logic [33:0] expQ[$];
   logic        heldValid;
   logic [33:0] heldResult;

   logic [31:0] vecA[11];
   logic [33:0] vecExp[11];

   f2i_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .p_lost    (p_lost),
      .invalid   (invalid)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference conversion: build the real value as a scaled integer, truncate,
   // apply the sign, then decide validity purely from the int32 range.
   // Result packing is {invalid, p_lost, d}.
   function automatic logic [33:0] refConvert(input logic [31:0] x);
      int     e;
      int     sh;
      longint m;
      longint mag;
      longint val;
      bit     lost;
      e = int'(x[30:23]);
      m = longint'(x[22:0]);
      if (e != 0) m = m + 64'sd8388608;
      if (e == 255 || e >= 160) return {1'b1, 1'b0, 32'h8000_0000};
      sh = ((e == 0) ? 1 : e) - 150;
      if (sh >= 0) begin
         mag  = m <<< sh;
         lost = 1'b0;
      end else if (sh <= -40) begin
         mag  = 0;
         lost = (m != 0);
      end else begin
         mag  = m >>> (-sh);
         lost = ((m & ((64'sd1 <<< (-sh)) - 64'sd1)) != 0);
      end
      val = x[31] ? -mag : mag;
      if (val > 64'sd2147483647 || val < -64'sd2147483648)
         return {1'b1, 1'b0, 32'h8000_0000};
      return {1'b0, lost, val[31:0]};
   endfunction

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Drive one cycle's worth of inputs
   task automatic applyStimulus(input logic v, input logic [31:0] val, input logic rdy);
      in_valid  = v;
      a         = val;
      out_ready = rdy;
   endtask

   // Advance to just after the next rising edge
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Let the pipeline empty out, bounded so a stuck design cannot hang the run
   task automatic drainPipe();
      applyStimulus(1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 40; i++) begin
         if (expQ.size() == 0) break;
         stepCycle();
      end
      checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
   endtask

   // Random float with exponents concentrated around the interesting range
   function automatic logic [31:0] randFloat();
      logic [7:0]  e8;
      logic [22:0] f23;
      int          pick;
      pick = $urandom_range(0, 9);
      if (pick < 6)       e8 = 8'($urandom_range(120, 160));
      else if (pick == 6) e8 = 8'd0;
      else if (pick == 7) e8 = 8'd255;
      else if (pick == 8) e8 = 8'd158;
      else                e8 = 8'($urandom_range(0, 255));
      f23 = ($urandom_range(0, 4) == 0) ? 23'd0 : 23'($urandom);
      return {1'($urandom), e8, f23};
   endfunction

   // Scoreboard / monitor on the falling edge: reset quietness, output hold
   // while stalled, in-order result matching, and flag exclusivity.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
         heldValid = 1'b0;
         checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
         checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
         checkOutput("rst_outputs", 64'({invalid, p_lost, d}), 64'd0);
      end else begin
         if (heldValid) begin
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_result", 64'({invalid, p_lost, d}), 64'(heldResult));
         end
         if (out_valid) begin
            checkOutput("flags_exclusive", 64'(invalid && p_lost), 64'd0);
         end
         if (out_valid && out_ready) begin
            checkOutput("result_expected", 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) begin
               checkOutput("result", 64'({invalid, p_lost, d}), 64'(expQ.pop_front()));
            end
         end
         if (in_valid && in_ready) expQ.push_back(refConvert(a));
         heldValid  = out_valid && !out_ready;
         heldResult = {invalid, p_lost, d};
      end
   end

   // Absolute time limit in case the design stops responding
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main stimulus sequence
   initial begin
      checkCount = 0;
      passCount  = 0;
      heldValid  = 1'b0;
      heldResult = '0;
      rst = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0);

      vecA[0]  = 32'h3F80_0000; vecExp[0]  = {1'b0, 1'b0, 32'h0000_0001};
      vecA[1]  = 32'hC049_0FDB; vecExp[1]  = {1'b0, 1'b1, 32'hFFFF_FFFD};
      vecA[2]  = 32'h4B00_0001; vecExp[2]  = {1'b0, 1'b0, 32'h0080_0001};
      vecA[3]  = 32'h4EFF_FFFF; vecExp[3]  = {1'b0, 1'b0, 32'h7FFF_FF80};
      vecA[4]  = 32'h4F00_0000; vecExp[4]  = {1'b1, 1'b0, 32'h8000_0000};
      vecA[5]  = 32'hCF00_0000; vecExp[5]  = {1'b0, 1'b0, 32'h8000_0000};
      vecA[6]  = 32'h7FC0_0000; vecExp[6]  = {1'b1, 1'b0, 32'h8000_0000};
      vecA[7]  = 32'hFF80_0000; vecExp[7]  = {1'b1, 1'b0, 32'h8000_0000};
      vecA[8]  = 32'h8000_0000; vecExp[8]  = {1'b0, 1'b0, 32'h0000_0000};
      vecA[9]  = 32'h0000_0001; vecExp[9]  = {1'b0, 1'b1, 32'h0000_0000};
      vecA[10] = 32'h3F7F_FFFF; vecExp[10] = {1'b0, 1'b1, 32'h0000_0000};

      // Reset state, then first cycle out of reset must be ready
      repeat (3) stepCycle();
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

      // Pin the reference model to hand-computed values
      foreach (vecA[i]) checkOutput("model_pin", 64'(refConvert(vecA[i])), 64'(vecExp[i]));

      // Two-cycle latency for 1.0
      applyStimulus(1'b1, 32'h3F80_0000, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 32'd0, 1'b1);
      #1;
      checkOutput("latency_cycle1_valid", 64'(out_valid), 64'd0);
      stepCycle();
      checkOutput("latency_cycle2_valid", 64'(out_valid), 64'd1);
      checkOutput("latency_cycle2_result", 64'({invalid, p_lost, d}), 64'({1'b0, 1'b0, 32'd1}));
      drainPipe();

      // Directed vectors back to back through the DUT
      foreach (vecA[i]) begin
         applyStimulus(1'b1, vecA[i], 1'b1);
         stepCycle();
      end
      drainPipe();

      // Stall: 1.0, 2.0, 3.0, 4.0 with out_ready low for four cycles
      applyStimulus(1'b1, 32'h3F80_0000, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 32'h4000_0000, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 32'h4040_0000, 1'b0);
      #1;
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_d_first", 64'({out_valid, d}), 64'({1'b1, 32'd1}));
      stepCycle();
      checkOutput("stall_d_second", 64'({out_valid, d}), 64'({1'b1, 32'd1}));
      stepCycle();
      applyStimulus(1'b1, 32'h4040_0000, 1'b1);
      stepCycle();
      applyStimulus(1'b1, 32'h4080_0000, 1'b1);
      stepCycle();
      drainPipe();

      // Reset pulse with the pipeline full, then a fresh 5.0
      applyStimulus(1'b1, 32'h3F80_0000, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 32'h4000_0000, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 32'h4040_0000, 1'b0);
      stepCycle();
      rst = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0);
      stepCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 32'd0, 1'b1);
      #1;
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
      stepCycle();
      checkOutput("flush_stays_empty", 64'(out_valid), 64'd0);
      applyStimulus(1'b1, 32'h40A0_0000, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 32'd0, 1'b1);
      stepCycle();
      checkOutput("after_flush_result", 64'({out_valid, invalid, p_lost, d}),
                  64'({1'b1, 1'b0, 1'b0, 32'd5}));
      drainPipe();

      // Random traffic with random back-pressure and occasional reset
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), randFloat(),
                       1'($urandom_range(0, 2) != 0));
         rst = ($urandom_range(0, 249) == 0);
         stepCycle();
      end
      rst = 1'b0;
      drainPipe();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
